// File: rtl/serial_mag_cmp_pkg.sv
// serial_mag_cmp_pkg
// Shared definitions for the serial magnitude comparator: FSM state type,
// slice width and the slice-count helper.
package serial_mag_cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned SLICE_W = 2;

    function automatic int unsigned nslices(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/serial_mag_cmp_slice2.sv
// cmp_slice2
// Combinational 2-bit unsigned magnitude comparator; exactly one output is high.
// Ports:
//   a, b : 2-bit operands
//   g    : a > b
//   e    : a == b
//   l    : a < b
module cmp_slice2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       g,
    output logic       e,
    output logic       l
);

    always_comb begin
        g = (a > b);
        e = (a == b);
        l = (a < b);
    end

endmodule

// File: rtl/serial_mag_cmp.sv
// serial_mag_cmp
// Sequential WIDTH-bit unsigned magnitude comparator. Operands are captured on
// START and walked MSB-first, two bits per clock, through a single cmp_slice2.
// The first differing slice fixes the verdict; equality over all slices gives E.
//
// Parameters:
//   WIDTH : operand width, even and >= 2 (N = WIDTH/2 slices)
// Ports:
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   START : compare request, sampled only in IDLE
//   A, B  : unsigned operands, captured on the accepting edge
//   BUSY  : high while a compare is running
//   DONE  : one-cycle pulse, G/E/L valid
//   G/E/L : A > B / A == B / A < B, held until the next DONE
//
// Build option:
//   SERIAL_MAG_CMP_EARLY_EXIT_EN : when defined, finish on the first differing
//   slice instead of always running all N slices. Verdict is unchanged.
module serial_mag_cmp
    import serial_mag_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic             G,
    output logic             E,
    output logic             L
);

    localparam int unsigned N  = nslices(WIDTH);
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             decided_q;
    logic             vg_q, vl_q;     // verdict accumulated so far in this run
    logic             done_q;
    logic             g_q, e_q, l_q;

    logic [SLICE_W-1:0] sa, sb;
    logic               sg, se, sl;
    logic               vg_d, vl_d, decided_d;
    logic               last;

    assign sa = a_q[{k_q, 1'b0} +: SLICE_W];
    assign sb = b_q[{k_q, 1'b0} +: SLICE_W];

    cmp_slice2 u_slice (
        .a (sa),
        .b (sb),
        .g (sg),
        .e (se),
        .l (sl)
    );

    always_comb begin
        vg_d      = vg_q;
        vl_d      = vl_q;
        decided_d = decided_q;
        // Only the most significant differing slice may set the verdict.
        if (!decided_q && !se) begin
            vg_d      = sg;
            vl_d      = sl;
            decided_d = 1'b1;
        end
        last = (k_q == '0);
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
        if (!decided_q && !se) begin
            last = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            k_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            decided_q <= 1'b0;
            vg_q      <= 1'b0;
            vl_q      <= 1'b0;
            done_q    <= 1'b0;
            g_q       <= 1'b0;
            e_q       <= 1'b0;
            l_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        a_q       <= A;
                        b_q       <= B;
                        k_q       <= KW'(N - 1);
                        decided_q <= 1'b0;
                        vg_q      <= 1'b0;
                        vl_q      <= 1'b0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    decided_q <= decided_d;
                    vg_q      <= vg_d;
                    vl_q      <= vl_d;
                    if (last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        g_q     <= vg_d;
                        l_q     <= vl_d;
                        e_q     <= !(vg_d || vl_d);
                    end else begin
                        k_q <= k_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BUSY = (state_q == RUN);
    assign DONE = done_q;
    assign G    = g_q;
    assign E    = e_q;
    assign L    = l_q;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// tb_serial_mag_cmp
// Directed bench for serial_mag_cmp (WIDTH=8). Stimulus pushes the expected
// verdict and DONE cycle into a queue; a negedge monitor pops on every DONE.
module tb_serial_mag_cmp;

`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [2:0] V_G = 3'b100;
    localparam logic [2:0] V_E = 3'b010;
    localparam logic [2:0] V_L = 3'b001;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       START;
    logic [7:0] A, B;
    logic       BUSY, DONE, G, E, L;

    serial_mag_cmp #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .G     (G),
        .E     (E),
        .L     (L)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] gel;
        int         cyc;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_done = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            exp_t e;
            check("done_not_back_to_back", {31'b0, prev_done}, 32'd0);
            check("done_has_expectation", {31'b0, q.size() > 0}, 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.name, "_gel"}, {29'b0, G, E, L}, {29'b0, e.gel});
                check({e.name, "_done_cycle"}, cyc, e.cyc);
            end
        end
        prev_done = DONE;
    end

    // Drive one request at the current negedge; the next posedge accepts it.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] gel,
                         input int lat, input string name);
        exp_t e;
        A     = a;
        B     = b;
        START = 1'b1;
        e.gel  = gel;
        e.cyc  = cyc + 1 + lat;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic wait_drain(input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            if (q.size() == 0) break;
            @(negedge CLK);
        end
        check({name, "_drained"}, q.size(), 32'd0);
    endtask

    initial begin
        int lat;
        RST_N = 1'b0;
        START = 1'b0;
        A     = '0;
        B     = '0;
        #12;
        check("reset_busy", {31'b0, BUSY}, 32'd0);
        check("reset_done", {31'b0, DONE}, 32'd0);
        check("reset_gel", {29'b0, G, E, L}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Equal operands: full length, E.
        @(negedge CLK);
        issue(8'hA5, 8'hA5, V_E, 4, "eq_a5");
        @(negedge CLK);
        START = 1'b0;
        wait_drain(20, "eq_a5");

        // MSB slice differs: G, early exit at e0+1 when enabled.
        @(negedge CLK);
        issue(8'h80, 8'h7F, V_G, EARLY ? 1 : 4, "gt_80_7f");
        @(negedge CLK);
        START = 1'b0;
        wait_drain(20, "gt_80_7f");

        // Only LSB slice differs: L, full length in both builds.
        @(negedge CLK);
        issue(8'h12, 8'h13, V_L, 4, "lt_12_13");
        @(negedge CLK);
        START = 1'b0;
        wait_drain(20, "lt_12_13");

        // START during RUN is ignored; BUSY stays high without gaps.
        lat = EARLY ? 1 : 4;
        @(negedge CLK);
        issue(8'h40, 8'h30, V_G, lat, "busy_ign");
        @(negedge CLK);                      // after e0
        A = 8'h00;
        B = 8'hFF;
        check("busy_after_e0", {31'b0, BUSY}, 32'd1);
        @(negedge CLK);                      // after e0+1
        START = 1'b0;
        check("busy_after_e0p1", {31'b0, BUSY}, {31'b0, lat > 1});
        for (int i = 2; i < lat; i++) begin
            @(negedge CLK);
            check("busy_in_run", {31'b0, BUSY}, 32'd1);
        end
        wait_drain(20, "busy_ign");
        repeat (6) @(negedge CLK);
        check("busy_ign_idle", {31'b0, BUSY}, 32'd0);

        // START held high: one result every 5 cycles, alternating L/G.
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) issue(8'h01, 8'h02, V_L, 4, "stream_lt");
            else            issue(8'h02, 8'h01, V_G, 4, "stream_gt");
            repeat (5) @(negedge CLK);
        end
        START = 1'b0;
        wait_drain(20, "stream");

        // Asynchronous reset two cycles into RUN aborts the compare.
        @(negedge CLK);
        issue(8'h33, 8'h33, V_E, 4, "abort");
        @(posedge CLK);                      // e0
        @(negedge CLK);
        START = 1'b0;
        @(posedge CLK);                      // e0+1
        @(posedge CLK);                      // e0+2
        #2;
        q.delete();
        RST_N = 1'b0;
        #1;
        check("abort_busy", {31'b0, BUSY}, 32'd0);
        check("abort_done", {31'b0, DONE}, 32'd0);
        check("abort_gel", {29'b0, G, E, L}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        check("abort_no_restart", {31'b0, BUSY}, 32'd0);
        check("abort_no_done", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule

// File: doc/serial_mag_cmp.md
# serial_mag_cmp

Sequential N-bit magnitude comparator. It walks two registered operands MSB-first in 2-bit slices through a 2-bit greater/equal/less slice stage and folds each slice's result into one registered G/E/L verdict. It feeds the 2-bit slice comparator and consumes its outputs. It exists so that wide compares cost one small slice stage plus a counter instead of a wide combinational tree.

## Interface
Parameters:
- WIDTH, default 8: operand width. Must be even and ≥ 2. N = WIDTH/2 slices.

Ports:
- CLK, input, 1: single clock. All state updates on the rising edge.
- RST_N, input, 1: reset. Asynchronous and active-low.
- START, input, 1: request a compare. Sampled only in IDLE.
- A, input, WIDTH: operand A, unsigned. Captured on the accepting edge.
- B, input, WIDTH: operand B, unsigned. Captured on the accepting edge.
- BUSY, output, 1: high while in RUN.
- DONE, output, 1: one-cycle pulse; the result is valid.
- G, output, 1: A > B. Registered, held until the next DONE.
- E, output, 1: A == B. Registered, held until the next DONE.
- L, output, 1: A < B. Registered, held until the next DONE.

## Operation
- States:
  - IDLE: START=1 on an edge captures A and B, sets slice index k=N-1 and enters RUN.
  - RUN: each edge evaluates slice k, i.e. bits [2k+1:2k] of the captured operands.
- Slice evaluation:
  - The slice stage gives g/e/l for the pair.
  - An internal flag `decided` records whether an earlier (more significant) slice already differed.
  - If no slice has differed yet and g or l is set, latch the verdict: G=g, L=l, E=0.
  - Less-significant slices never override a latched verdict.
- Completion edge is the edge evaluating k=0, or the early-exit edge (see Configuration). On that edge:
  - DONE←1 and state←IDLE.
  - G/E/L←final verdict. If every slice was equal, E=1 and G=L=0.
- G/E/L are one-hot whenever DONE has fired at least once.
- START in RUN is ignored. A and B changing during RUN have no effect.
- START high in the cycle DONE is high is accepted, because state is already IDLE.
- Reset values, applied asynchronously: state=IDLE, BUSY=0, DONE=0, G=0, E=0, L=0, k=0, decided=0.
- Reset mid-RUN aborts the compare. No DONE follows.

## Timing
- Let the accepting edge be e0.
- BUSY is high from after e0 until after the completion edge.
- Full-length latency: completion at edge e0+N. DONE is high for exactly the cycle after e0+N.
- Early exit: completion at edge e0+j, where j (1..N) is the MSB-first position of the first differing slice.
- Maximum throughput with START held high: one result every N+1 cycles.
- DONE never stays high for two consecutive cycles.

## Configuration
- Macro: SERIAL_MAG_CMP_EARLY_EXIT_EN.
- Defined: RUN ends on the first edge whose slice differs. Latency is data-dependent, 1..N.
- Undefined: RUN always lasts N edges. Latency is constant N, and later slices are evaluated but ignored.
- The verdict is identical in both builds. Only DONE timing differs.

## Structure
Shared package serial_mag_cmp_pkg holds:
- state enum: IDLE, RUN.
- SLICE_W = 2.
- function nslices(WIDTH) returning WIDTH/2.

Sub-module cmp_slice2 is combinational:
- Inputs: a[1:0], b[1:0].
- Outputs: g, e, l.
- Instantiated once. It is the only magnitude logic in the block.

## Test plan
All scenarios use WIDTH=8, so N=4.
- A=0xA5, B=0xA5, START pulse → DONE after edge e0+4; E=1, G=0, L=0.
- A=0x80, B=0x7F → G=1, E=0, L=0. DONE after e0+1 with SERIAL_MAG_CMP_EARLY_EXIT_EN defined, after e0+4 without it.
- A=0x12, B=0x13 → L=1, E=0, G=0. DONE after e0+4 in both builds.
- START accepted with 0x40/0x30. On the next edge START=1 with A=0x00, B=0xFF. → Second request ignored. First result is G=1 with a single DONE. BUSY stays high without gaps until completion.
- START held high, operands alternating 0x01/0x02 and 0x02/0x01 → DONE every 5 cycles with L, G, L, G, …; no DONE on consecutive cycles.
- RST_N driven low asynchronously two cycles into RUN → BUSY, DONE, G, E, L go to 0 immediately. After release, no DONE appears without a new START.
